// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory port arbiter: access-size encodings,
//   the arbiter FSM state type and the encoding of which requester owns the
//   access currently in flight.
package mem_arb_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_byte_lane_unit.sv
// byte_lane_unit
//   Combinational byte-lane steering for the load/store port.
//   Ports:
//     size      in  2   access size (SZ_B / SZ_H / SZ_W, 3 reserved)
//     offset    in  2   byte offset within the word
//     we        in  1   1 = store, 0 = load
//     wdata     in  32  right-aligned store data
//     rdata     in  32  raw memory read word
//     mem_we    out 4   byte-lane write enables (0 for loads and errors)
//     mem_wdata out 32  store data replicated across all candidate lanes
//     rdata_al  out 32  read word shifted so the addressed byte is at bit 0
//     err       out 1   misaligned access or reserved size
module byte_lane_unit
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    output logic [31:0] rdata_al,
    output logic        err
);

    // Lane selection and data replication per access size. Replicating the
    // store data means the memory only needs lane enables, not a shifter.
    always_comb begin
        err       = 1'b0;
        mem_we    = 4'b0000;
        mem_wdata = '0;
        case (size)
            SZ_B: begin
                mem_we    = 4'b0001 << offset;
                mem_wdata = {4{wdata[7:0]}};
            end
            SZ_H: begin
                err       = offset[0];
                mem_we    = offset[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{wdata[15:0]}};
            end
            SZ_W: begin
                err       = |offset;
                mem_we    = 4'b1111;
                mem_wdata = wdata;
            end
            default: begin
                err = 1'b1;
            end
        endcase
        if (!we || err) begin
            mem_we = 4'b0000;
        end
    end

    // Loads are returned right-aligned; the core does any sign extension.
    assign rdata_al = rdata >> {offset, 3'b000};

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between instruction fetch and
//   the load/store port. Data has priority, but after MAX_DATA_RUN back-to-back
//   data grants with fetch waiting, fetch gets the next slot.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     if_req/if_addr        fetch request and word address
//     if_gnt/if_rvalid      fetch accepted / fetch data valid pulse
//     if_rdata              fetched word (held between pulses)
//     d_req/d_we/d_addr     data request, store flag, byte address
//     d_size/d_wdata        access size, right-aligned store data
//     d_gnt/d_rvalid        data accepted / load data or store ack pulse
//     d_rdata/d_err         aligned load data (held), error flag with pulse
//     mem_en/mem_we         memory strobe and byte-lane write enables
//     mem_addr/mem_wdata    word-aligned address, lane-replicated data
//     mem_rdata             memory read word, valid MEM_LAT cycles after mem_en
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam int RUN_W = (MAX_DATA_RUN < 2) ? 1 : $clog2(MAX_DATA_RUN + 1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_DATA_RUN);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t            state, next_state;
    owner_t            owner;
    logic [LAT_W-1:0]  lat_cnt;
    logic [RUN_W-1:0]  run_cnt;
    logic [1:0]        off;
    logic              err;
    logic              store;
    logic [31:0]       if_rdata_q, d_rdata_q, d_rdata_live;

    logic [1:0]        lane_off;
    logic [3:0]        lane_we;
    logic [31:0]       lane_wdata, lane_rdata;
    logic              lane_err;

    // In IDLE the lane unit steers the incoming request; in WAIT it aligns
    // read data using the offset captured at grant.
    assign lane_off = (state == IDLE) ? d_addr[1:0] : off;

    byte_lane_unit u_lanes (
        .size      (d_size),
        .offset    (lane_off),
        .we        (d_we),
        .wdata     (d_wdata),
        .rdata     (mem_rdata),
        .mem_we    (lane_we),
        .mem_wdata (lane_wdata),
        .rdata_al  (lane_rdata),
        .err       (lane_err)
    );

    // Same-cycle arbitration in IDLE and the rvalid pulse at the end of WAIT.
    // Everything is suppressed while rst is high so reset wins over traffic.
    always_comb begin
        next_state = state;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (d_req && (!if_req || run_cnt < RUN_MAX)) begin
                        d_gnt      = 1'b1;
                        mem_en     = !lane_err;
                        mem_we     = lane_we;
                        mem_addr   = d_addr & WORD_MASK;
                        mem_wdata  = lane_wdata;
                        next_state = WAIT;
                    end else if (if_req) begin
                        if_gnt     = 1'b1;
                        mem_en     = 1'b1;
                        mem_addr   = if_addr & WORD_MASK;
                        next_state = WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_ONE) begin
                        if (owner == OWN_DATA) begin
                            d_rvalid = 1'b1;
                        end else begin
                            if_rvalid = 1'b1;
                        end
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Errors and store acks return zero; the live value bypasses the holding
    // register so data appears in the same cycle as its rvalid pulse.
    assign d_rdata_live = (err || store) ? 32'h0 : lane_rdata;
    assign d_rdata      = d_rvalid ? d_rdata_live : d_rdata_q;
    assign if_rdata     = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_err        = d_rvalid & err;

    // State, in-flight access bookkeeping, fetch starvation counter and the
    // read-data holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_FETCH;
            lat_cnt    <= '0;
            run_cnt    <= '0;
            off        <= 2'b00;
            err        <= 1'b0;
            store      <= 1'b0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state <= next_state;
            if (if_gnt || d_gnt) begin
                lat_cnt <= LAT_INIT;
                owner   <= d_gnt ? OWN_DATA : OWN_FETCH;
                off     <= d_addr[1:0];
                err     <= d_gnt & lane_err;
                store   <= d_gnt & d_we;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - LAT_ONE;
            end
            if (!if_req || if_gnt) begin
                run_cnt <= '0;
            end else if (d_gnt && run_cnt < RUN_MAX) begin
                run_cnt <= run_cnt + 1'b1;
            end
            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= d_rdata_live;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with MEM_LAT = 1, MAX_DATA_RUN = 4.
//   The bench plays the memory by driving mem_rdata directly per vector.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int vectorCount = 0;
    int missCount   = 0;

    mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(1), .MAX_DATA_RUN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_size    (d_size),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present a data request just after a rising edge, then settle to the
    // falling edge where the grant cycle is sampled.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [1:0] size, input logic [31:0] wdata,
                                 input logic [31:0] rdata);
        @(posedge clk);
        #1;
        d_req     = 1'b1;
        d_we      = we;
        d_addr    = addr;
        d_size    = size;
        d_wdata   = wdata;
        mem_rdata = rdata;
        @(negedge clk);
    endtask

    // Drop all requests after the next edge and sample at the falling edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
        d_req  = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
    endtask

    string expOrder = "DDDDFDDDDF";
    string gotOrder;
    int    overlap;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_size = 2'd2; d_wdata = '0; mem_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset ctrl", {25'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en, |mem_we}, 32'h0);
        checkOutput("reset if_rdata", if_rdata, 32'h0);
        checkOutput("reset d_rdata", d_rdata, 32'h0);

        // Fetch only, back-to-back requests
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        checkOutput("fetch gnt", {29'd0, if_gnt, d_gnt, mem_en}, 32'h5);
        checkOutput("fetch addr", mem_addr, 32'h10);
        @(posedge clk);
        #1;
        if_addr = 32'h14;
        @(negedge clk);
        checkOutput("fetch rvalid", {30'd0, if_rvalid, if_gnt}, 32'h2);
        checkOutput("fetch rdata", if_rdata, 32'h0050_0093);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("fetch regrant T+2", {31'd0, if_gnt}, 32'h1);
        checkOutput("fetch addr 2", mem_addr, 32'h14);
        @(posedge clk);
        #1;
        if_req = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("fetch rdata 2", if_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        checkOutput("fetch rdata hold", {if_rdata[31:1], if_rvalid}, {31'h6F56_DF77, 1'b0});

        // sb at 0x103
        applyStimulus(1'b1, 32'h103, 2'd0, 32'h0000_00AB, 32'h0);
        checkOutput("sb ctrl", {27'd0, d_gnt, mem_en, mem_we[3:1]}, {27'd0, 2'b11, 3'b100});
        checkOutput("sb we", {28'd0, mem_we}, 32'h8);
        checkOutput("sb wdata", mem_wdata, 32'hABAB_ABAB);
        checkOutput("sb addr", mem_addr, 32'h100);
        nextCycle();
        checkOutput("sb ack", {29'd0, d_rvalid, d_err, d_gnt}, 32'h4);
        checkOutput("sb ack rdata", d_rdata, 32'h0);

        // sh at 0x102
        applyStimulus(1'b1, 32'h102, 2'd1, 32'h1234_ABCD, 32'h0);
        checkOutput("sh we", {28'd0, mem_we}, 32'hC);
        checkOutput("sh wdata", mem_wdata, 32'hABCD_ABCD);
        nextCycle();
        checkOutput("sh ack", {30'd0, d_rvalid, d_err}, 32'h2);

        // Misaligned sw at 0x105
        applyStimulus(1'b1, 32'h105, 2'd2, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        checkOutput("sw mis gnt", {27'd0, d_gnt, mem_en, 3'd0}, 32'h10);
        checkOutput("sw mis we", {28'd0, mem_we}, 32'h0);
        nextCycle();
        checkOutput("sw mis resp", {30'd0, d_rvalid, d_err}, 32'h3);
        checkOutput("sw mis rdata", d_rdata, 32'h0);

        // Reserved size load
        applyStimulus(1'b0, 32'h100, 2'd3, 32'h0, 32'hFFFF_FFFF);
        checkOutput("sz3 gnt", {30'd0, d_gnt, mem_en}, 32'h2);
        nextCycle();
        checkOutput("sz3 resp", {30'd0, d_rvalid, d_err}, 32'h3);
        checkOutput("sz3 rdata", d_rdata, 32'h0);

        // lh at 0x202
        applyStimulus(1'b0, 32'h202, 2'd1, 32'h0, 32'h8001_1234);
        checkOutput("lh gnt", {26'd0, d_gnt, mem_en, mem_we}, {26'd0, 2'b11, 4'h0});
        checkOutput("lh addr", mem_addr, 32'h200);
        nextCycle();
        checkOutput("lh resp", {30'd0, d_rvalid, d_err}, 32'h2);
        checkOutput("lh rdata", d_rdata, 32'h0000_8001);

        // lb at 0x101
        applyStimulus(1'b0, 32'h101, 2'd0, 32'h0, 32'h1122_3344);
        nextCycle();
        checkOutput("lb rdata", d_rdata, 32'h0011_2233);

        // Both requesters held high: fetch gets every fifth slot
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h80; d_size = 2'd2; mem_rdata = 32'h0BAD_F00D;
        gotOrder = "";
        overlap  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((if_gnt || d_gnt) && (if_rvalid || d_rvalid)) overlap++;
            if (d_gnt) gotOrder = {gotOrder, "D"};
            else if (if_gnt) gotOrder = {gotOrder, "F"};
            @(posedge clk);
        end
        #1;
        if_req = 1'b0; d_req = 1'b0;
        checkOutput("arb grant count", gotOrder.len(), expOrder.len());
        for (int i = 0; i < expOrder.len(); i++) begin
            checkOutput($sformatf("arb order %0d", i),
                        (i < gotOrder.len()) ? {24'd0, gotOrder[i]} : 32'h0,
                        {24'd0, expOrder[i]});
        end
        checkOutput("arb gnt/rvalid overlap", overlap, 0);

        // Reset during the WAIT of a load
        applyStimulus(1'b0, 32'h300, 2'd2, 32'h0, 32'h5555_AAAA);
        checkOutput("rst load gnt", {31'd0, d_gnt}, 32'h1);
        @(posedge clk);
        #1;
        d_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        checkOutput("rst kills rvalid", {31'd0, d_rvalid}, 32'h0);
        @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_size = 2'd2; mem_rdata = 32'h7777_1111;
        @(negedge clk);
        checkOutput("rst outputs ctrl",
                    {25'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en, |mem_we}, 32'h0);
        checkOutput("rst if_rdata", if_rdata, 32'h0);
        checkOutput("rst d_rdata", d_rdata, 32'h0);
        checkOutput("rst mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post rst gnt", {30'd0, d_gnt, mem_en}, 32'h3);
        checkOutput("post rst addr", mem_addr, 32'h44);
        nextCycle();
        checkOutput("post rst rvalid", {31'd0, d_rvalid}, 32'h1);
        checkOutput("post rst rdata", d_rdata, 32'h7777_1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: the instruction-fetch port and the load/store data port of the rv32 core.
- Arbitrates with data priority and a starvation guard for fetch.
- Generates byte-lane write enables for sb/sh/sw and lane-aligns load data.
- Returns read data and write acks through a valid pulse.
- Sits between the pc/decoder/alu datapath and the memory, and replaces direct dual-read memory access.

Parameters:
- ADDR_W, 32, byte-address width.
- MEM_LAT, 1, memory read latency in cycles (≥1). mem_rdata is valid MEM_LAT cycles after mem_en.
- MAX_DATA_RUN, 4, maximum consecutive data grants while if_req is pending. The next arbitration then goes to fetch.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request. Held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch byte address. Word-aligned by the requester; bits [1:0] ignored.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetched word.
- d_req  in  1  data request. Held with all d_* fields stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_size  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved.
- d_wdata  in  32  store data, right-aligned (bits [7:0] for a byte).
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse. Load data valid, or store ack.
- d_rdata  out  32  load data shifted so the addressed byte sits at bit 0. No sign extension; the core extends.
- d_err  out  1  valid with d_rvalid. Set for misaligned access or d_size=3.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  byte-lane write enables.
- mem_addr  out  ADDR_W  byte address with [1:0] forced to 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read word.

Behaviour:
- FSM states: IDLE, WAIT.
  - Counter lat_cnt counts down from MEM_LAT.
  - Register owner (0 fetch, 1 data) records who was granted.
  - Registers off and err capture the byte offset and error flag at grant.
- Arbitration happens only in IDLE and is combinational in the same cycle.
  - Winner = data if d_req and (!if_req or run_cnt < MAX_DATA_RUN).
  - Otherwise the winner is fetch if if_req.
  - Winner's gnt = 1. mem_* are driven from the winner's fields in that cycle.
  - Next state: WAIT with lat_cnt = MEM_LAT.
- run_cnt:
  - +1 on each data grant while if_req = 1, saturating at MAX_DATA_RUN.
  - Cleared on fetch grant, or in any cycle with if_req = 0.
- WAIT:
  - lat_cnt decrements each cycle. No grants.
  - In the cycle lat_cnt == 1, assert the owner's rvalid, then return to IDLE.
  - Throughput: one access per MEM_LAT+1 cycles. gnt and rvalid never coincide.
- Lane rules, off = d_addr[1:0]:
  - byte: mem_we = 1<<off; mem_wdata = {4{d_wdata[7:0]}}.
  - half: mem_we = off[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{d_wdata[15:0]}}.
  - word: mem_we = 4'hF; mem_wdata = d_wdata.
  - Loads: mem_we = 0. d_rdata = mem_rdata >> (8*off).
- Error cases: half with off[0] = 1, word with off ≠ 0, or d_size = 3.
  - Request is granted but mem_en and mem_we stay 0. The FSM still runs the WAIT sequence.
  - d_rvalid pulses with d_err = 1 and d_rdata = 0.
- Store ack: d_rvalid pulses with d_rdata = 0 and d_err = 0.
- Fetch: if_rdata = mem_rdata, unshifted.
- rdata outputs are registered and hold their value between pulses.
- Reset:
  - All outputs are 0 the cycle after rst is seen high. State IDLE, run_cnt = 0.
  - rst mid-WAIT discards the access; no rvalid is emitted.
- rst has priority over all other events.

Decomposition:
- Shared package mem_arb_pkg holds:
  - Size encodings SZ_B = 0, SZ_H = 1, SZ_W = 2.
  - State enum IDLE/WAIT.
  - Owner encoding.
- One sub-module, byte_lane_unit: combinational. Inputs size, offset, we, wdata, rdata. Outputs mem_we, mem_wdata, aligned rdata, err.

Test Plan:
- Fetch only, MEM_LAT = 1, if_addr = 0x10, mem word 0x00500093 → if_gnt at T, mem_en = 1 with mem_addr = 0x10 at T, if_rvalid with if_rdata = 0x00500093 at T+1, next grant no earlier than T+2.
- sb, d_addr = 0x103, d_wdata = 0xAB → mem_we = 4'b1000, mem_wdata = 0xABABABAB, d_rvalid at T+1 with d_err = 0.
- lh, d_addr = 0x202, mem_rdata = 0x8001_1234 → mem_we = 0, d_rdata = 0x0000_8001 at T+1.
- Misaligned sw at 0x105, and d_size = 3 → d_gnt = 1, mem_en = 0, d_rvalid with d_err = 1, d_rdata = 0.
- if_req and d_req held high continuously, MAX_DATA_RUN = 4 → grant order D,D,D,D,F,D,D,D,D,F.
- rst asserted during WAIT of a load → no d_rvalid; all outputs 0 the next cycle; a fresh request is granted in the first IDLE cycle after rst deasserts.
